spi_stream_arbiter: RTL and testbench

- Schedules the MCU SPI readout link between two sources: the raw-sample FIFO and the spike-event FIFO.
- On each MCU poll it grants one source and emits one framed burst (header, length, payload) into the SPI slave TX word interface.
- It sits between the two FWFT FIFOs and the SPI TX serializer, in the MCU interface block.

---
 rtl/spi_stream_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_spi_stream_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_arbiter.sv
`timescale 1ns/1ps
// Arbitrates the MCU SPI readout between the raw-sample and spike-event FIFOs and frames one burst per poll.
// Define SPI_ARB_CHECKSUM_EN to append a 16-bit running-sum trailer word to every non-idle frame.
module spi_stream_arbiter #(
  parameter logic [15:0] RAW_HEADER   = 16'hC691,
  parameter logic [15:0] SPIKE_HEADER = 16'h1999,
  parameter logic [15:0] IDLE_HEADER  = 16'h0000,
  parameter int          RAW_LEN      = 700,
  parameter int          SPIKE_MAX    = 64,
  parameter int          CNT_W        = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             poll,
  input  logic [CNT_W-1:0] raw_cnt,
  input  logic [15:0]      raw_data,
  input  logic             raw_almost_full,
  output logic             raw_rd_en,
  input  logic [CNT_W-1:0] spike_cnt,
  input  logic [15:0]      spike_data,
  output logic             spike_rd_en,
  output logic [15:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             grant_spike,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] RAW_LEN_C   = CNT_W'(RAW_LEN);
  localparam logic [CNT_W-1:0] SPIKE_MAX_C = CNT_W'(SPIKE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_DATA,
`ifdef SPI_ARB_CHECKSUM_EN
    S_SUM,
`endif
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             idle_q, idle_d;
  logic             grant_spike_q, grant_spike_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SPI_ARB_CHECKSUM_EN
  logic [15:0]      sum_q, sum_d;
`endif

  logic             raw_ok, spike_ok, pick_spike, xfer;
  logic [CNT_W-1:0] spike_len;

  assign raw_ok    = raw_cnt >= RAW_LEN_C;
  assign spike_ok  = spike_cnt != '0;
  assign spike_len = (spike_cnt > SPIKE_MAX_C) ? SPIKE_MAX_C : spike_cnt;
  assign xfer      = tx_valid && tx_ready;

  // Almost-full raw preempts fairness; otherwise alternate on a tie.
  always_comb begin
    if (raw_almost_full && raw_ok)  pick_spike = 1'b0;
    else if (raw_ok && spike_ok)    pick_spike = ~last_grant_q;
    else                            pick_spike = spike_ok;
  end

  always_comb begin
    state_d       = state_q;
    idle_d        = idle_q;
    grant_spike_d = grant_spike_q;
    last_grant_d  = last_grant_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
`ifdef SPI_ARB_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (state_q)
      S_IDLE: if (poll) begin
        state_d = S_HDR;
        idle_d  = !(raw_ok || spike_ok);
        cnt_d   = '0;
`ifdef SPI_ARB_CHECKSUM_EN
        sum_d   = '0;
`endif
        if (raw_ok || spike_ok) begin
          grant_spike_d = pick_spike;
          len_d         = pick_spike ? spike_len : RAW_LEN_C;
        end
      end
      S_HDR: if (xfer) begin
        state_d = idle_q ? S_DONE : S_LEN;
`ifdef SPI_ARB_CHECKSUM_EN
        sum_d   = sum_q + tx_data;
`endif
      end
      S_LEN: if (xfer) begin
        state_d = S_DATA;
`ifdef SPI_ARB_CHECKSUM_EN
        sum_d   = sum_q + tx_data;
`endif
      end
      S_DATA: if (xfer) begin
        cnt_d = cnt_q + 1'b1;
`ifdef SPI_ARB_CHECKSUM_EN
        sum_d = sum_q + tx_data;
        if (cnt_q == len_q - 1'b1) state_d = S_SUM;
`else
        if (cnt_q == len_q - 1'b1) state_d = S_DONE;
`endif
      end
`ifdef SPI_ARB_CHECKSUM_EN
      S_SUM: if (xfer) state_d = S_DONE;
`endif
      S_DONE: begin
        state_d = S_IDLE;
        if (!idle_q) last_grant_d = grant_spike_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idle_q        <= 1'b0;
      grant_spike_q <= 1'b0;
      last_grant_q  <= 1'b1;
      len_q         <= '0;
      cnt_q         <= '0;
`ifdef SPI_ARB_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idle_q        <= idle_d;
      grant_spike_q <= grant_spike_d;
      last_grant_q  <= last_grant_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
`ifdef SPI_ARB_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  // Word path decodes straight from registered state so a stall holds it unchanged.
  always_comb begin
    tx_valid    = 1'b0;
    tx_data     = '0;
    raw_rd_en   = 1'b0;
    spike_rd_en = 1'b0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = idle_q ? IDLE_HEADER : (grant_spike_q ? SPIKE_HEADER : RAW_HEADER);
      end
      S_LEN: begin
        tx_valid = 1'b1;
        tx_data  = 16'(len_q);
      end
      S_DATA: begin
        tx_valid    = 1'b1;
        tx_data     = grant_spike_q ? spike_data : raw_data;
        raw_rd_en   = tx_ready && !grant_spike_q;
        spike_rd_en = tx_ready && grant_spike_q;
      end
`ifdef SPI_ARB_CHECKSUM_EN
      S_SUM: begin
        tx_valid = 1'b1;
        tx_data  = sum_q;
      end
`endif
      default: ;
    endcase
  end

  assign busy        = state_q != S_IDLE;
  assign frame_done  = state_q == S_DONE;
  assign grant_spike = grant_spike_q;

endmodule

// File: tb/tb_spi_stream_arbiter.sv
`timescale 1ns/1ps
// Randomized bench for spi_stream_arbiter: FIFO models feed the DUT, a frame-level model predicts each burst.
module tb_spi_stream_arbiter;

  localparam int RAW_LEN   = 700;
  localparam int SPIKE_MAX = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        poll;
  logic [12:0] raw_cnt, spike_cnt;
  logic [15:0] raw_data, spike_data;
  logic        raw_almost_full, raw_rd_en, spike_rd_en;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, busy, grant_spike, frame_done;

  spi_stream_arbiter dut (
    .clk(clk), .rst(rst), .poll(poll),
    .raw_cnt(raw_cnt), .raw_data(raw_data), .raw_almost_full(raw_almost_full), .raw_rd_en(raw_rd_en),
    .spike_cnt(spike_cnt), .spike_data(spike_data), .spike_rd_en(spike_rd_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .grant_spike(grant_spike), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;
  logic [31:0] salt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO models: head word is a salted function of the pop index.
  int raw_idx = 0, spike_idx = 0;
  bit raw_pop_n = 0, spike_pop_n = 0;
  function automatic logic [15:0] raw_word(input int i);
    return 16'(i * 40503) ^ salt[15:0];
  endfunction
  function automatic logic [15:0] spike_word(input int i);
    return 16'(i * 29531 + 7) ^ salt[31:16];
  endfunction
  assign raw_data   = raw_word(raw_idx);
  assign spike_data = spike_word(spike_idx);
  always @(posedge clk) begin
    if (raw_pop_n)   raw_idx   <= raw_idx + 1;
    if (spike_pop_n) spike_idx <= spike_idx + 1;
  end

  // Bus monitor
  logic [15:0] got_q[$];
  int raw_pops, spike_pops, rd_viol, hold_viol;
  bit stall_prev;
  logic [15:0] prev_data;
  always @(negedge clk) begin
    raw_pop_n   = raw_rd_en;
    spike_pop_n = spike_rd_en;
    if (rst) stall_prev = 0;
    else begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (raw_rd_en) raw_pops++;
      if (spike_rd_en) spike_pops++;
      if ((raw_rd_en || spike_rd_en) && !tx_ready) rd_viol++;
      if (stall_prev && (!tx_valid || tx_data !== prev_data)) hold_viol++;
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // Reference model state: last granted source (1 = spike) and visible grant
  bit m_last, m_gs;

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_raw_rd"}, raw_rd_en, 0);
    chk({tag, "_spike_rd"}, spike_rd_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant_spike, 0);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  task automatic run_frame(input string tag, input int rc, input int sc, input bit af,
                           input bit rnd, input bit mid_poll);
    logic [15:0] exp_q[$];
    logic [15:0] sum;
    int g, len, cyc, nbad, nmin;
    bit raw_ok, spike_ok, busy_bad;
    raw_ok   = rc >= RAW_LEN;
    spike_ok = sc != 0;
    if (af && raw_ok)            g = 0;
    else if (raw_ok && spike_ok) g = m_last ? 0 : 1;
    else if (raw_ok)             g = 0;
    else if (spike_ok)           g = 1;
    else                         g = 2;
    len = (g == 0) ? RAW_LEN : (g == 1) ? ((sc < SPIKE_MAX) ? sc : SPIKE_MAX) : 0;
    if (g == 2) exp_q.push_back(16'h0000);
    else begin
      exp_q.push_back(g == 0 ? 16'hC691 : 16'h1999);
      exp_q.push_back(16'(len));
      for (int i = 0; i < len; i++)
        exp_q.push_back(g == 0 ? raw_word(raw_idx + i) : spike_word(spike_idx + i));
`ifdef SPI_ARB_CHECKSUM_EN
      sum = '0;
      foreach (exp_q[i]) sum = sum + exp_q[i];
      exp_q.push_back(sum);
`endif
    end

    @(posedge clk); #1;
    raw_cnt = 13'(rc); spike_cnt = 13'(sc); raw_almost_full = af;
    tx_ready = 1'b1; poll = 1'b1;
    got_q.delete(); raw_pops = 0; spike_pops = 0; rd_viol = 0; hold_viol = 0; stall_prev = 0;
    @(posedge clk); #1;
    poll = 1'b0;
    if (rnd) tx_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({tag, "_hdr_valid"}, tx_valid, 1);
    chk({tag, "_hdr_word"}, tx_data, exp_q[0]);
    cyc = 0;
    while (!frame_done && cyc < 6000) begin
      @(posedge clk); #1;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      if (mid_poll) poll = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    poll = 1'b0;
    tx_ready = 1'b1;
    chk({tag, "_done_seen"}, frame_done, 1);
    if (!rnd) chk({tag, "_done_cycle"}, cyc, exp_q.size());
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    nbad = 0;
    for (int i = 0; i < nmin; i++) if (got_q[i] !== exp_q[i]) nbad++;
    chk({tag, "_bad_words"}, nbad, 0);
    if (nmin > 1) chk({tag, "_len_word"}, got_q[1], exp_q[1]);
    if (nmin > 0) chk({tag, "_last_word"}, got_q[nmin-1], exp_q[nmin-1]);
    chk({tag, "_raw_pops"}, raw_pops, (g == 0) ? len : 0);
    chk({tag, "_spike_pops"}, spike_pops, (g == 1) ? len : 0);
    chk({tag, "_grant"}, grant_spike, (g == 2) ? m_gs : 1'(g));
    chk({tag, "_rd_unready"}, rd_viol, 0);
    chk({tag, "_stall_hold"}, hold_viol, 0);
    busy_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || tx_valid || frame_done) busy_bad = 1;
    end
    chk({tag, "_idle_after"}, busy_bad, 0);
    if (g != 2) begin m_last = 1'(g); m_gs = 1'(g); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1'b1; m_gs = 1'b0;
  endtask

  task automatic rst_mid();
    @(posedge clk); #1;
    raw_cnt = 13'd0; spike_cnt = 13'd100; raw_almost_full = 1'b0; tx_ready = 1'b1; poll = 1'b1;
    @(posedge clk); #1;
    poll = 1'b0;
    repeat (20) begin @(posedge clk); #1; tx_ready = 1'($urandom_range(0, 1)); end
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_grant", grant_spike, 1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1'b1; m_gs = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, sc;
    salt = $urandom;
    rst = 1'b1; poll = 1'b0; raw_cnt = '0; spike_cnt = '0; raw_almost_full = 1'b0; tx_ready = 1'b1;
    m_last = 1'b1; m_gs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("por");
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame("raw800", 800, 0, 0, 0, 0);
    run_frame("spike10", 0, 10, 0, 0, 0);
    run_frame("spike100", 0, 100, 0, 0, 0);

    do_reset();
    run_frame("rr1", 800, 5, 0, 0, 0);
    run_frame("rr2", 800, 5, 0, 0, 0);
    run_frame("rr3", 800, 5, 0, 0, 0);
    run_frame("afull", 800, 5, 1, 0, 0);
    run_frame("afull_spike", 800, 5, 0, 0, 0);

    run_frame("idle0", 0, 0, 0, 0, 0);
    run_frame("idle699", 699, 0, 1, 0, 0);
    run_frame("raw700", 700, 0, 0, 0, 0);
    run_frame("spike1", 699, 1, 1, 0, 0);
    run_frame("midpoll", 0, 10, 0, 0, 1);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: rc = 0;
        1: rc = 699;
        2: rc = 700;
        default: rc = int'($urandom_range(0, 8191));
      endcase
      case ($urandom_range(0, 4))
        0: sc = 0;
        1: sc = 1;
        2: sc = 64;
        3: sc = 65;
        default: sc = int'($urandom_range(0, 200));
      endcase
      run_frame($sformatf("rand%0d", k), rc, sc, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end

    rst_mid();
    run_frame("post_rst", 800, 5, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
